// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline controllers: the wait-state FSM
// encoding, the default IO page selector and the wait counter width.
package pipe_ctrl_pkg;

  localparam int CNT_W = 8;

  localparam logic [3:0] IO_PAGE_DEF = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } stall_state_t;

endpackage

// File: rtl/stall_wait_counter.sv
// stall_wait_counter
// Loadable down-counter for MEM-stage wait states. Saturates at zero.
// Ports:
//   clock    in   pipeline clock
//   resetn   in   async active-low reset, clears the count
//   load     in   load load_val (has priority over dec)
//   load_val in   CNT_W value to load
//   dec      in   decrement by one unless already zero
//   zero     out  count is zero
module stall_wait_counter
  import pipe_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_io_stall_ctrl.sv
// pipe_io_stall_ctrl
// MEM-stage wait-state controller. A load/store to the IO page freezes the
// upstream pipeline and bubbles MEM/WB until the IO access completes.
// Build option: MEMSTALL_IO_ACK_EN selects ack-terminated accesses with a
// TIMEOUT watchdog; otherwise each access takes exactly WAIT_CYCLES.
// Ports:
//   clock, resetn   pipeline clock, async active-low reset
//   mm2reg, mwmem   MEM-stage load / store
//   malu[31:0]      MEM-stage effective address
//   io_ack          IO device done (ack build only)
//   freeze          hold PC, IF/ID, ID/EX, EX/MEM
//   mw_bubble       zero mwreg/mm2reg at the MEM/WB input
//   io_req, io_wen  IO bus access in progress / is a write
//   io_timeout      sticky ack timeout flag
//
// state   | meaning
// IDLE    | no IO access; a hit freezes this cycle and starts one
// WAIT    | IO access in progress, pipeline frozen
// RELEASE | last IO cycle; instruction advances into MEM/WB
module pipe_io_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [3:0]  IO_PAGE     = IO_PAGE_DEF,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic        io_ack,
  output logic        freeze,
  output logic        mw_bubble,
  output logic        io_req,
  output logic        io_wen,
  output logic        io_timeout
);

  localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

  stall_state_t state;
  logic         wen_q;
  logic         hit;
  logic         cnt_load;
  logic         cnt_dec;
  logic         cnt_zero;
  logic [CNT_W-1:0] entry_load;
  logic         unused_bits;

  assign hit = (mm2reg | mwmem) & (malu[31:28] == IO_PAGE);

`ifdef MEMSTALL_IO_ACK_EN
  assign entry_load = TIMEOUT_LOAD;
`else
  assign entry_load = WAIT_LOAD;
`endif

  assign unused_bits = ^{malu[27:0], io_ack, WAIT_LOAD, TIMEOUT_LOAD};

  assign cnt_load = (state == IDLE) & hit;
  assign cnt_dec  = (state == WAIT);

  stall_wait_counter u_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (entry_load),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef MEMSTALL_IO_ACK_EN
  logic timeout_q;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      wen_q <= 1'b0;
`ifdef MEMSTALL_IO_ACK_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state <= WAIT;
            wen_q <= mwmem;
          end
        end
        WAIT: begin
`ifdef MEMSTALL_IO_ACK_EN
          // ack wins over a coincident timeout: the access did complete
          if (io_ack) begin
            state <= RELEASE;
          end else if (cnt_zero) begin
            state     <= RELEASE;
            timeout_q <= 1'b1;
          end
`else
          if (cnt_zero) state <= RELEASE;
`endif
        end
        // hit is deliberately ignored here so the same instruction is not re-served
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded outputs are gated by resetn: IDLE+hit would otherwise freeze during reset.
  always_comb begin
    freeze    = 1'b0;
    mw_bubble = 1'b0;
    io_req    = 1'b0;
    io_wen    = 1'b0;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          freeze    = hit;
          mw_bubble = hit;
        end
        WAIT: begin
          freeze    = 1'b1;
          mw_bubble = 1'b1;
          io_req    = 1'b1;
          io_wen    = wen_q;
        end
        RELEASE: begin
          io_req = 1'b1;
          io_wen = wen_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MEMSTALL_IO_ACK_EN
  assign io_timeout = timeout_q;
`else
  assign io_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_io_stall_ctrl.sv
// tb_pipe_io_stall_ctrl
// Directed pipeline scenarios plus a randomized run, checked every cycle
// against a behavioural model of the IO wait-state rules.
module tb_pipe_io_stall_ctrl;

  localparam int WC = 4;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mm2reg = 1'b0;
  logic        mwmem = 1'b0;
  logic [31:0] malu = '0;
  logic        io_ack = 1'b0;
  logic        freeze, mw_bubble, io_req, io_wen, io_timeout;

  int passed = 0;
  int total  = 0;

  pipe_io_stall_ctrl #(
    .WAIT_CYCLES (WC),
    .IO_PAGE     (4'hC),
    .TIMEOUT     (TO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .malu       (malu),
    .io_ack     (io_ack),
    .freeze     (freeze),
    .mw_bubble  (mw_bubble),
    .io_req     (io_req),
    .io_wen     (io_wen),
    .io_timeout (io_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: an access is "waiting" with m_w wait cycles elapsed, then one release cycle.
  bit m_wait, m_rel, m_wen, m_tmo;
  int m_w;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_wait = 0; m_rel = 0; m_wen = 0; m_tmo = 0; m_w = 0;
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_wait) begin
      m_w++;
`ifdef MEMSTALL_IO_ACK_EN
      if (io_ack) begin
        m_wait = 0; m_rel = 1;
      end else if (m_w == TO) begin
        m_wait = 0; m_rel = 1; m_tmo = 1;
      end
`else
      if (m_w == WC) begin
        m_wait = 0; m_rel = 1;
      end
`endif
    end else if ((mm2reg || mwmem) && malu[31:28] == 4'hC) begin
      m_wait = 1; m_w = 0; m_wen = mwmem;
    end
  end

  always @(negedge clock) begin
    logic [4:0] exp_v, act_v;
    bit h;
    h = (mm2reg || mwmem) && malu[31:28] == 4'hC;
    if (!resetn)     exp_v = 5'b0;
    else if (m_rel)  exp_v = {1'b0, 1'b0, 1'b1, m_wen, m_tmo};
    else if (m_wait) exp_v = {1'b1, 1'b1, 1'b1, m_wen, m_tmo};
    else             exp_v = {h, h, 1'b0, 1'b0, m_tmo};
    act_v = {freeze, mw_bubble, io_req, io_wen, io_timeout};
    total++;
    if (act_v === exp_v) passed++;
    else $display("FAIL cycle_outputs {frz,bub,req,wen,tmo}: got %b expected %b at %0t",
                  act_v, exp_v, $time);
  end

  // Presents one instruction in MEM and holds it until the pipeline lets it advance.
  // Called at posedge+1; returns at posedge+1 after the instruction left MEM.
  task automatic run_instr(input bit ld, input bit st, input logic [31:0] addr,
                           input int ack_at, output int nfz, output int nreq,
                           output int nbub, output int nwb, output int first_req,
                           output int nwen);
    bit fz;
    bit done;
    mm2reg = ld; mwmem = st; malu = addr;
    nfz = 0; nreq = 0; nbub = 0; nwb = 0; nwen = 0; first_req = -1; done = 0;
    for (int c = 0; c < 300; c++) begin
      io_ack = (ack_at != 0) && (c == ack_at);
      @(negedge clock);
      if (freeze) nfz++;
      if (mw_bubble) nbub++; else nwb++;
      if (io_req) begin
        nreq++;
        if (io_wen) nwen++;
        if (first_req < 0) first_req = c;
      end
      fz = freeze;
      @(posedge clock); #1;
      if (!fz) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("instr_cycle_bound", 0, 1);
    mm2reg = 0; mwmem = 0; malu = '0; io_ack = 0;
  endtask

  int nfz, nreq, nbub, nwb, freq, nwen;

  initial begin
    #2;
    chk("reset_outputs", {freeze, mw_bubble, io_req, io_wen, io_timeout}, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1;

    // IO load: 5-cycle freeze, io_req T+1..T+5, one writeback
    run_instr(1, 0, 32'hC000_0010, 0, nfz, nreq, nbub, nwb, freq, nwen);
    chk("ld_freeze_cycles", nfz, 5);
    chk("ld_bubble_cycles", nbub, 5);
    chk("ld_req_cycles", nreq, 5);
    chk("ld_first_req", freq, 1);
    chk("ld_wen_cycles", nwen, 0);
    chk("ld_writebacks", nwb, 1);

    // non-IO store passes straight through
    run_instr(0, 1, 32'h0000_0040, 0, nfz, nreq, nbub, nwb, freq, nwen);
    chk("mem_st_freeze", nfz, 0);
    chk("mem_st_req", nreq, 0);
    chk("mem_st_writebacks", nwb, 1);

    // back-to-back IO stores
    run_instr(0, 1, 32'hC000_0000, 0, nfz, nreq, nbub, nwb, freq, nwen);
    chk("st1_freeze", nfz, 5);
    chk("st1_wen", nwen, 5);
    run_instr(0, 1, 32'hC000_0004, 0, nfz, nreq, nbub, nwb, freq, nwen);
    chk("st2_freeze", nfz, 5);
    chk("st2_wen", nwen, 5);
    chk("st2_first_req", freq, 1);

    // reset in the 2nd WAIT cycle
    mm2reg = 1; malu = 32'hC000_0020;
    repeat (2) @(posedge clock);
    #3 resetn = 0;
    mm2reg = 0; malu = '0;
    #1 chk("reset_mid_wait", {freeze, mw_bubble, io_req}, 0);
    @(posedge clock); #1 resetn = 1;
    @(posedge clock); #1;
    run_instr(1, 0, 32'hC000_0030, 0, nfz, nreq, nbub, nwb, freq, nwen);
    chk("post_reset_freeze", nfz, 5);
    chk("post_reset_req", nreq, 5);

`ifdef MEMSTALL_IO_ACK_EN
    run_instr(1, 0, 32'hC000_0100, 3, nfz, nreq, nbub, nwb, freq, nwen);
    chk("ack3_freeze", nfz, 4);
    chk("ack3_req", nreq, 4);
    chk("ack3_timeout", io_timeout, 0);
    run_instr(0, 1, 32'hC000_0104, 1, nfz, nreq, nbub, nwb, freq, nwen);
    chk("ack1_min_freeze", nfz, 2);
    run_instr(1, 0, 32'hC000_0108, 0, nfz, nreq, nbub, nwb, freq, nwen);
    chk("timeout_freeze", nfz, TO + 1);
    chk("timeout_req", nreq, TO + 1);
    repeat (3) @(posedge clock);
    #1 chk("timeout_sticky", io_timeout, 1);
    resetn = 0;
    #1 chk("timeout_cleared", io_timeout, 0);
    @(posedge clock); #1 resetn = 1;
`else
    run_instr(1, 0, 32'hC000_0100, 2, nfz, nreq, nbub, nwb, freq, nwen);
    chk("ack_ignored_freeze", nfz, 5);
    chk("no_timeout", io_timeout, 0);
`endif

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  page;
      logic [27:0] off;
      page = ($urandom_range(0, 1) == 1) ? 4'hC : 4'($urandom_range(0, 15));
      off  = 28'($urandom);
      mm2reg = ($urandom_range(0, 2) == 0);
      mwmem  = ($urandom_range(0, 2) == 0);
      malu   = {page, off};
      io_ack = ($urandom_range(0, 5) == 0);
      resetn = ($urandom_range(0, 99) != 0);
      @(posedge clock); #1;
    end
    resetn = 1; mm2reg = 0; mwmem = 0; io_ack = 0;
    repeat (2) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_io_stall_ctrl.md
# pipe_io_stall_ctrl

Memory-stage wait-state controller for the 5-stage pipelined computer. It detects load/store instructions in the MEM stage that target the memory-mapped IO page and freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) until the IO access completes. While frozen it injects a bubble into the MEM/WB register, so that no writeback is duplicated. It sits beside the EX/MEM and MEM/WB registers and drives their enable/clear controls plus the IO bus request.

## Interface
- WAIT_CYCLES, 4, fixed IO wait states per access; legal range 1..255.
- IO_PAGE, 4'hC, value of malu[31:28] that selects the IO page.
- TIMEOUT, 64, maximum WAIT cycles in ack mode; legal range 1..255 (ack mode only).

- clock  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mm2reg  in  1  MEM-stage instruction is a load.
- mwmem  in  1  MEM-stage instruction is a store.
- malu  in  32  MEM-stage effective address.
- io_ack  in  1  IO device done (ack mode only).
- freeze  out  1  hold PC, IF/ID, ID/EX, EX/MEM (enable = ~freeze).
- mw_bubble  out  1  force mwreg/mm2reg to 0 at the MEM/WB input.
- io_req  out  1  IO bus access in progress.
- io_wen  out  1  IO access is a write; valid while io_req=1.
- io_timeout  out  1  sticky: an ack-mode access timed out.

## Operation
- hit = (mm2reg | mwmem) & (malu[31:28] == IO_PAGE).
- FSM states: IDLE, WAIT, RELEASE.
- IDLE, when hit=0: all outputs 0 (io_timeout holds its value).
- IDLE, when hit=1: freeze=1 and mw_bubble=1 combinationally in the same cycle. Next state is WAIT; cnt loads WAIT_CYCLES-1; wen_q latches mwmem.
- WAIT: freeze=1, mw_bubble=1, io_req=1, io_wen=wen_q. If cnt==0, go to RELEASE; otherwise cnt decrements.
- RELEASE: freeze=0, mw_bubble=0, io_req=1, io_wen=wen_q.
  - Load data is valid this cycle.
  - The instruction advances into MEM/WB at the closing edge.
  - Next state is IDLE unconditionally; hit is not evaluated in RELEASE, so the same instruction is never re-served.
- Back-to-back IO accesses: the following instruction reaches EX/MEM after RELEASE, is seen as hit in IDLE, and starts a new sequence.
- Non-IO memory accesses and non-memory instructions never stall.
- cnt is 8 bits wide and saturates at 0; it never wraps.

## Timing
- Detection cycle T: freeze high.
- WAIT occupies cycles T+1..T+WAIT_CYCLES.
- RELEASE occurs at T+WAIT_CYCLES+1.
- Total freeze = WAIT_CYCLES+1 cycles; io_req high for WAIT_CYCLES+1 cycles.
- Reset, asserted at any time including mid-WAIT: state=IDLE, cnt=0, wen_q=0, io_timeout=0 immediately. All outputs 0 while resetn=0.
- io_ack outside WAIT is ignored.

## Configuration
- MEMSTALL_IO_ACK_EN defined:
  - WAIT exits to RELEASE on io_ack=1, or when cnt reaches 0 after loading TIMEOUT-1 at entry.
  - Exiting on timeout without ack sets io_timeout=1 until reset.
  - io_ack=1 in the first WAIT cycle gives the minimum freeze of 2 cycles.
- MEMSTALL_IO_ACK_EN undefined:
  - Fixed WAIT_CYCLES behaviour; io_ack ignored; io_timeout tied to 0.

## Structure
- Shared package pipe_ctrl_pkg: state enum (IDLE/WAIT/RELEASE), IO_PAGE default, and the 8-bit count width constant. The other pipeline controllers reuse these.
- One sub-module, stall_wait_counter: loadable 8-bit down-counter with load, dec and zero outputs. The FSM and output decode stay in pipe_io_stall_ctrl.

## Test plan
- Load with malu=32'hC000_0010, WAIT_CYCLES=4 -> freeze high 5 cycles; mw_bubble high 5 cycles; io_req high cycles T+1..T+5; io_wen=0; instruction enters MEM/WB once.
- Store with malu=32'h0000_0040 -> no freeze, no io_req; single-cycle pass-through.
- Two consecutive IO stores (C000_0000, C000_0004) -> two separate 5-cycle freezes separated by exactly one RELEASE; io_wen=1 for both.
- resetn pulsed low in the 2nd WAIT cycle -> freeze, io_req and mw_bubble drop to 0 immediately; FSM in IDLE after release; next IO access stalls the full 5 cycles.
- Ack mode, io_ack at the 3rd WAIT cycle -> RELEASE next cycle; io_timeout=0.
- Ack mode, io_ack never asserted, TIMEOUT=8 -> RELEASE after 8 WAIT cycles; io_timeout=1 and held until reset.
